// File: rtl/logic_cmd_driver_pkg.sv
// Shared definitions for blocks that drive the 32-bit logic unit.
// Op codes, driver FSM states and the op-to-select map.
package logic_cmd_driver_pkg;

  typedef enum logic [2:0] {
    LOP_AND  = 3'd0,
    LOP_OR   = 3'd1,
    LOP_NOR  = 3'd2,
    LOP_NAND = 3'd3,
    LOP_XOR  = 3'd4,
    LOP_XNOR = 3'd5,
    LOP_NOT  = 3'd6,
    LOP_NEG  = 3'd7
  } lop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // The unit's select port is the op code bit-reversed.
  function automatic logic [2:0] sel_map(input logic [2:0] op);
    return {op[0], op[1], op[2]};
  endfunction

endpackage

// File: rtl/logic_sel_enc.sv
// Op code to logic-unit select encoder.
// Pure combinational; shared by every logic-unit initiator.
module logic_sel_enc
  import logic_cmd_driver_pkg::*;
(
  input  logic [2:0] op,
  output logic [2:0] sel
);

  assign sel = sel_map(op);

endmodule

// File: rtl/logic_cmd_driver.sv
// Initiator for the logic unit: command in, hold operands
// for a settle window, capture result, response out.
module logic_cmd_driver
  import logic_cmd_driver_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_select,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int SW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LD =
    SW'(SETTLE_CYC - 1);

  state_e        state;
  logic [SW-1:0] cnt;
  logic [2:0]    op_q;
  logic [2:0]    sel_enc;

  logic_sel_enc u_enc (
    .op  (cmd_op),
    .sel (sel_enc)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Command/settle/response sequencer; reset wins over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      lu_a      <= '0;
      lu_b      <= '0;
      lu_select <= '0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_zero  <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lu_a      <= cmd_a;
            lu_b      <= cmd_b;
            lu_select <= sel_enc;
            op_q      <= cmd_op;
            cnt       <= SETTLE_LD;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            rsp_data <= lu_out;
            rsp_zero <= (lu_out == '0);
            rsp_op   <= op_q;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_cmd_driver.sv
// Directed bench for logic_cmd_driver with a behavioural
// logic unit and an expected-response scoreboard.
module tb_logic_cmd_driver;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] data;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;

  logic        c1_valid, c1_ready, r1_valid, r1_ready;
  logic [31:0] l1_a, l1_b, l1_out, r1_data;
  logic [2:0]  l1_sel, r1_op;
  logic        r1_zero;
  logic [15:0] cnt1;

  logic        c3_valid, c3_ready, r3_valid, r3_ready;
  logic [31:0] l3_a, l3_b, l3_out, r3_data;
  logic [2:0]  l3_sel, r3_op;
  logic        r3_zero;
  logic [3:0]  cnt3;

  logic        ovr_en;
  logic [31:0] ovr_val;

  exp_t        q1[$];
  exp_t        q3[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt1;
  logic [3:0]  exp_cnt3;

  always #5 clk = ~clk;

  // Behavioural logic unit, addressed by its select code.
  function automatic logic [31:0] unit(
    input logic [2:0] s, input logic [31:0] a, b);
    case (s)
      3'b000:  return a & b;
      3'b100:  return a | b;
      3'b010:  return ~(a | b);
      3'b110:  return ~(a & b);
      3'b001:  return a ^ b;
      3'b101:  return ~(a ^ b);
      3'b011:  return ~a;
      default: return (~a) + 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] exp_res(
    input logic [2:0] op, input logic [31:0] a, b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~(a & b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return 32'd0 - a;
    endcase
  endfunction

  function automatic logic [2:0] exp_sel(input logic [2:0] op);
    case (op)
      3'd0:    return 3'b000;
      3'd1:    return 3'b100;
      3'd2:    return 3'b010;
      3'd3:    return 3'b110;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      3'd6:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  assign l1_out = unit(l1_sel, l1_a, l1_b);
  assign l3_out = ovr_en ? ovr_val : unit(l3_sel, l3_a, l3_b);

  logic_cmd_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (c1_valid),
    .cmd_ready (c1_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .lu_a      (l1_a),
    .lu_b      (l1_b),
    .lu_select (l1_sel),
    .lu_out    (l1_out),
    .rsp_valid (r1_valid),
    .rsp_ready (r1_ready),
    .rsp_data  (r1_data),
    .rsp_op    (r1_op),
    .rsp_zero  (r1_zero),
    .op_count  (cnt1)
  );

  logic_cmd_driver #(
    .WIDTH      (32),
    .SETTLE_CYC (3),
    .CNT_W      (4)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (c3_valid),
    .cmd_ready (c3_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .lu_a      (l3_a),
    .lu_b      (l3_b),
    .lu_select (l3_sel),
    .lu_out    (l3_out),
    .rsp_valid (r3_valid),
    .rsp_ready (r3_ready),
    .rsp_data  (r3_data),
    .rsp_op    (r3_op),
    .rsp_zero  (r3_zero),
    .op_count  (cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op,
                              input logic [31:0] a, b);
    exp_t e;
    e.op   = op;
    e.data = exp_res(op, a, b);
    e.zero = (e.data == 32'd0);
    return e;
  endfunction

  task automatic pop1();
    exp_t e;
    if (q1.size() == 0) begin
      chk("sb1_empty", 32'd1, 32'd0);
    end else begin
      e = q1.pop_front();
      chk("rsp1_data", r1_data, e.data);
      chk("rsp1_op", 32'(r1_op), 32'(e.op));
      chk("rsp1_zero", 32'(r1_zero), 32'(e.zero));
    end
  endtask

  task automatic pop3();
    exp_t e;
    if (q3.size() == 0) begin
      chk("sb3_empty", 32'd1, 32'd0);
    end else begin
      e = q3.pop_front();
      chk("rsp3_data", r3_data, e.data);
      chk("rsp3_op", 32'(r3_op), 32'(e.op));
      chk("rsp3_zero", 32'(r3_zero), 32'(e.zero));
    end
  endtask

  task automatic run1(input logic [2:0] op,
                      input logic [31:0] a, b);
    cmd_op = op; cmd_a = a; cmd_b = b;
    c1_valid = 1'b1;
    chk("rdy_pre", 32'(c1_ready), 32'd1);
    q1.push_back(mk(op, a, b));
    step();
    c1_valid = 1'b0;
    chk("sel", 32'(l1_sel), 32'(exp_sel(op)));
    chk("vld_n1", 32'(r1_valid), 32'd0);
    step();
    chk("vld_n2", 32'(r1_valid), 32'd1);
    pop1();
    r1_ready = 1'b1;
    step();
    r1_ready = 1'b0;
    exp_cnt1 = exp_cnt1 + 16'd1;
    chk("rdy_post", 32'(c1_ready), 32'd1);
    chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
  endtask

  task automatic run3(input logic [2:0] op,
                      input logic [31:0] a, b);
    cmd_op = op; cmd_a = a; cmd_b = b;
    c3_valid = 1'b1;
    q3.push_back(mk(op, a, b));
    step();
    c3_valid = 1'b0;
    step();
    step();
    chk("vld3_n3", 32'(r3_valid), 32'd0);
    step();
    chk("vld3_n4", 32'(r3_valid), 32'd1);
    pop3();
    r3_ready = 1'b1;
    step();
    r3_ready = 1'b0;
    exp_cnt3 = exp_cnt3 + 4'd1;
    chk("cnt3", 32'(cnt3), 32'(exp_cnt3));
  endtask

  initial begin
    logic [31:0] hold;
    rst = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    c1_valid = 1'b0; r1_ready = 1'b0;
    c3_valid = 1'b0; r3_ready = 1'b0;
    ovr_en = 1'b0; ovr_val = '0;
    exp_cnt1 = '0; exp_cnt3 = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_rdy", 32'(c1_ready), 32'd1);
    chk("rst_vld", 32'(r1_valid), 32'd0);
    chk("rst_sel", 32'(l1_sel), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_a", l1_a, 32'd0);
    chk("rst_b", l1_b, 32'd0);
    chk("rst_data", r1_data, 32'd0);

    run1(3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    for (int i = 1; i < 8; i++)
      run1(3'(i), 32'h0000FFFF, 32'h00FF00FF);
    run1(3'd7, 32'h00000001, 32'h0);
    run1(3'd4, 32'hA5A55A5A, 32'hA5A55A5A);

    cmd_op = 3'd1; cmd_a = 32'h12345678;
    cmd_b = 32'h0F0F0F0F;
    c1_valid = 1'b1;
    q1.push_back(mk(cmd_op, cmd_a, cmd_b));
    step();
    cmd_op = 3'd4; cmd_a = 32'hFFFF0000;
    cmd_b = 32'h0000FFFF;
    step();
    hold = r1_data;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(r1_valid), 32'd1);
      chk("bp_rdy", 32'(c1_ready), 32'd0);
      chk("bp_data", r1_data, hold);
      chk("bp_lua", l1_a, 32'h12345678);
      step();
    end
    pop1();
    r1_ready = 1'b1;
    step();
    r1_ready = 1'b0;
    exp_cnt1 = exp_cnt1 + 16'd1;
    chk("bp_idle_rdy", 32'(c1_ready), 32'd1);
    chk("bp_not_yet", l1_a, 32'h12345678);
    q1.push_back(mk(cmd_op, cmd_a, cmd_b));
    step();
    c1_valid = 1'b0;
    chk("bp_second_a", l1_a, 32'hFFFF0000);
    chk("bp_second_rdy", 32'(c1_ready), 32'd0);
    step();
    chk("bp_second_vld", 32'(r1_valid), 32'd1);
    pop1();
    r1_ready = 1'b1;
    step();
    r1_ready = 1'b0;
    exp_cnt1 = exp_cnt1 + 16'd1;
    chk("bp_cnt", 32'(cnt1), 32'(exp_cnt1));

    cmd_op = 3'd3; cmd_a = 32'h1; cmd_b = 32'h3;
    c1_valid = 1'b1;
    step();
    c1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt1 = '0;
    chk("rd_vld", 32'(r1_valid), 32'd0);
    chk("rd_rdy", 32'(c1_ready), 32'd1);
    chk("rd_cnt", 32'(cnt1), 32'd0);
    chk("rd_lua", l1_a, 32'd0);
    chk("rd_sel", 32'(l1_sel), 32'd0);

    run1(3'd5, 32'h00000000, 32'hFFFFFFFF);
    cmd_op = 3'd1; cmd_a = 32'h80; cmd_b = 32'h1;
    c1_valid = 1'b1;
    step();
    c1_valid = 1'b0;
    step();
    chk("rr_in_resp", 32'(r1_valid), 32'd1);
    rst = 1'b1;
    r1_ready = 1'b1;
    step();
    rst = 1'b0;
    r1_ready = 1'b0;
    exp_cnt1 = '0;
    q1.delete();
    chk("rr_vld", 32'(r1_valid), 32'd0);
    chk("rr_cnt", 32'(cnt1), 32'd0);
    chk("rr_data", r1_data, 32'd0);
    chk("rr_op", 32'(r1_op), 32'd0);
    chk("rr_zero", 32'(r1_zero), 32'd0);

    cmd_op = 3'd0; cmd_a = 32'hFFFF0000;
    cmd_b = 32'hFF00FF00;
    c3_valid = 1'b1;
    chk("s3_rdy", 32'(c3_ready), 32'd1);
    q3.push_back(mk(cmd_op, cmd_a, cmd_b));
    step();
    c3_valid = 1'b0;
    ovr_en = 1'b1;
    ovr_val = 32'hDEADBEEF;
    chk("s3_sel", 32'(l3_sel), 32'd0);
    step();
    chk("s3_vld_n2", 32'(r3_valid), 32'd0);
    step();
    ovr_en = 1'b0;
    chk("s3_vld_n3", 32'(r3_valid), 32'd0);
    step();
    chk("s3_vld_n4", 32'(r3_valid), 32'd1);
    pop3();
    r3_ready = 1'b1;
    step();
    r3_ready = 1'b0;
    exp_cnt3 = exp_cnt3 + 4'd1;
    chk("s3_cnt", 32'(cnt3), 32'(exp_cnt3));

    for (int i = 0; i < 15; i++)
      run3(3'(i), $urandom, $urandom);
    chk("wrap", 32'(cnt3), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
